// File: rtl/etapa_mem_acceso.sv
// MIPS memory-access stage: branch resolution, req/ack data-memory port with byte
// lanes, load filtering, write-back selection and the MEM/WB register.
module etapa_mem_acceso #(
  parameter int NBITS   = 32,
  parameter int REGS    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Valid,
  input  logic [NBITS-1:0] i_ALU,
  input  logic [NBITS-1:0] i_Registro2,
  input  logic [REGS-1:0]  i_RegistroDestino,
  input  logic [NBITS-1:0] i_PC8,
  input  logic [NBITS-1:0] i_PCBranch,
  input  logic [NBITS-1:0] i_Extension,
  input  logic             i_Cero,
  input  logic             i_Branch,
  input  logic             i_NBranch,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_TamanoFiltro,
  input  logic [1:0]       i_TamanoFiltroL,
  input  logic             i_ZeroExtend,
  input  logic             i_JAL,
  input  logic             i_LUI,
  input  logic             i_MemToReg,
  input  logic             i_RegWrite,
  input  logic             i_MemAck,
  input  logic [NBITS-1:0] i_MemRData,
  output logic             o_MemReq,
  output logic             o_MemWe,
  output logic [NBITS-1:0] o_MemAddr,
  output logic [NBITS-1:0] o_MemWData,
  output logic [3:0]       o_MemBE,
  output logic             o_Stall,
  output logic             o_PCSrc,
  output logic [NBITS-1:0] o_PCBranch,
  output logic             o_WB_Valid,
  output logic [NBITS-1:0] o_WB_Data,
  output logic [REGS-1:0]  o_WB_RegistroDestino,
  output logic             o_WB_RegWrite,
  output logic             o_AddrError,
  output logic             o_Timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic             r_wb_valid;
  logic [NBITS-1:0] r_wb_data;
  logic [REGS-1:0]  r_wb_dest;
  logic             r_wb_regwrite;
  logic             r_addr_err;
  logic             r_timeout;

  logic             w_memop;
  logic             w_misal;
  logic [1:0]       w_tam;
  logic [1:0]       w_lane;
  logic             w_stall;
  logic             w_req;
  logic             w_wb_commit;
  logic             w_wb_err;
  logic             w_wb_to;
  logic [NBITS-1:0] w_load;
  logic [NBITS-1:0] w_wb_sel;
  logic             w_unused;

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [NBITS-1:0] f_filtro_carga(input logic [NBITS-1:0] dato,
                                                      input logic [1:0]       lane,
                                                      input logic [1:0]       tam,
                                                      input logic             zext);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [NBITS-1:0] r;
    case (lane)
      2'd0:    b = dato[7:0];
      2'd1:    b = dato[15:8];
      2'd2:    b = dato[23:16];
      default: b = dato[31:24];
    endcase
    h = lane[1] ? dato[31:16] : dato[15:0];
    if (tam == 2'b00)
      r = zext ? {{(NBITS-8){1'b0}}, b} : {{(NBITS-8){b[7]}}, b};
    else if (tam == 2'b01)
      r = zext ? {{(NBITS-16){1'b0}}, h} : {{(NBITS-16){h[15]}}, h};
    else
      r = dato;
    return r;
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [1:0] tam, input logic [1:0] lane);
    logic [3:0] be;
    if (tam == 2'b00)
      be = 4'b0001 << lane;
    else if (tam == 2'b01)
      be = lane[1] ? 4'b1100 : 4'b0011;
    else
      be = 4'b1111;
    return be;
  endfunction

  // Replicate narrow store data into every lane; the byte enables pick the live one.
  function automatic logic [NBITS-1:0] f_dato_esc(input logic [1:0]       tam,
                                                  input logic [NBITS-1:0] dato);
    logic [NBITS-1:0] d;
    if (tam == 2'b00)
      d = {(NBITS/8){dato[7:0]}};
    else if (tam == 2'b01)
      d = {(NBITS/16){dato[15:0]}};
    else
      d = dato;
    return d;
  endfunction

  assign w_memop  = i_Valid & (i_MemRead | i_MemWrite);
  assign w_tam    = i_MemWrite ? i_TamanoFiltro : i_TamanoFiltroL;
  assign w_lane   = i_ALU[1:0];
  assign w_misal  = w_memop & (((w_tam == 2'b01) & i_ALU[0]) |
                               (w_tam[1] & (i_ALU[1:0] != 2'b00)));
  assign w_unused = ^i_Extension[NBITS-1:16];

  assign w_load = f_filtro_carga(i_MemRData, w_lane, i_TamanoFiltroL, i_ZeroExtend);

  always_comb begin
    w_wb_sel = i_ALU;
    if (i_JAL)
      w_wb_sel = i_PC8;
    else if (i_LUI)
      w_wb_sel = {i_Extension[15:0], {(NBITS-16){1'b0}}};
    else if (i_MemToReg)
      w_wb_sel = w_load;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Ack is tested before the timeout so a late ack on the last cycle still commits.
  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_req       = 1'b0;
    w_wb_commit = 1'b0;
    w_wb_err    = 1'b0;
    w_wb_to     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_misal) begin
          w_wb_err = 1'b1;
        end else if (w_memop) begin
          w_stall = 1'b1;
          w_next  = ST_WAIT;
        end else if (i_Valid) begin
          w_wb_commit = 1'b1;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (i_MemAck) begin
          w_wb_commit = 1'b1;
          w_next      = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_wb_to = 1'b1;
          w_next  = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                r_cnt <= '0;
    else if (r_state == ST_IDLE) r_cnt <= '0;
    else                         r_cnt <= r_cnt + CNT_W'(1);
  end

  // MEM/WB boundary
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_dest     <= '0;
      r_wb_regwrite <= 1'b0;
      r_addr_err    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_wb_valid    <= w_wb_commit | w_wb_err | w_wb_to;
      r_wb_regwrite <= w_wb_commit & i_RegWrite;
      r_addr_err    <= w_wb_err;
      r_timeout     <= w_wb_to;
      if (w_wb_commit)
        r_wb_data <= w_wb_sel;
      if (w_wb_commit | w_wb_err | w_wb_to)
        r_wb_dest <= i_RegistroDestino;
    end
  end

  assign o_MemReq   = w_req;
  assign o_MemWe    = w_req & i_MemWrite;
  assign o_MemAddr  = {i_ALU[NBITS-1:2], 2'b00};
  assign o_MemWData = f_dato_esc(i_TamanoFiltro, i_Registro2);
  assign o_MemBE    = f_byte_en(w_tam, w_lane);
  assign o_Stall    = w_stall;
  assign o_PCSrc    = i_Valid & ((i_Branch & i_Cero) | (i_NBranch & ~i_Cero));
  assign o_PCBranch = i_PCBranch;

  assign o_WB_Valid           = r_wb_valid;
  assign o_WB_Data            = r_wb_data;
  assign o_WB_RegistroDestino = r_wb_dest;
  assign o_WB_RegWrite        = r_wb_regwrite;
  assign o_AddrError          = r_addr_err;
  assign o_Timeout            = r_timeout;

endmodule

// File: doc/etapa_mem_acceso.md
Name: etapa_mem_acceso

Overview:
- Consumes the EX/MEM pipeline fields and performs the MIPS memory-access stage.
- Resolves conditional branches.
- Drives a req/ack data-memory port with byte enables. Filters loads to byte, half or word with sign or zero extension.
- Selects the write-back value and registers it into the MEM/WB outputs.
- Stalls the pipeline while a memory access is outstanding, and flags misaligned accesses and memory timeouts.

Parameters:
NBITS, 32, datapath and address width
REGS, 5, register-index width
TIMEOUT, 16, maximum cycles to wait for i_MemAck before aborting the access

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-low
i_Valid  in  1  EX/MEM entry holds a real instruction
i_ALU  in  NBITS  ALU result / effective address
i_Registro2  in  NBITS  store data
i_RegistroDestino  in  REGS  destination register
i_PC8  in  NBITS  link address for JAL
i_PCBranch  in  NBITS  branch target
i_Extension  in  NBITS  sign-extended immediate
i_Cero  in  1  ALU zero flag
i_Branch, i_NBranch  in  1 each  BEQ / BNE
i_MemWrite, i_MemRead  in  1 each  store / load
i_TamanoFiltro  in  2  store size: 00 byte, 01 half, 1x word
i_TamanoFiltroL  in  2  load size, same encoding
i_ZeroExtend  in  1  1 = zero-extend a load, 0 = sign-extend
i_JAL, i_LUI, i_MemToReg, i_RegWrite  in  1 each  write-back control
i_MemAck  in  1  memory completes the access this cycle
i_MemRData  in  NBITS  read word, valid with i_MemAck
o_MemReq  out  1  access request
o_MemWe  out  1  1 = write
o_MemAddr  out  NBITS  word-aligned address ({i_ALU[NBITS-1:2],2'b00})
o_MemWData  out  NBITS  store data replicated into lanes
o_MemBE  out  4  byte enables
o_Stall  out  1  hold IF..EX/MEM this cycle
o_PCSrc  out  1  branch taken
o_PCBranch  out  NBITS  branch target passthrough
o_WB_Valid  out  1  MEM/WB entry valid
o_WB_Data  out  NBITS  write-back value
o_WB_RegistroDestino  out  REGS  write-back destination register
o_WB_RegWrite  out  1  register-file write enable
o_AddrError  out  1  one-cycle pulse: misaligned access
o_Timeout  out  1  one-cycle pulse: access aborted by timeout

Behaviour:
- Reset (async, i_reset=0):
  - state IDLE, timeout counter 0.
  - All registered outputs 0: o_WB_*, o_AddrError, o_Timeout.
  - o_MemReq=0.
- memop = i_Valid & (i_MemRead | i_MemWrite).
- Misalignment: misal = memop & ((half & i_ALU[0]) | (word & i_ALU[1:0]!=0)).
  - A misaligned op issues no request and does not stall.
  - Next edge: o_AddrError=1, o_WB_Valid=1, o_WB_RegWrite=0.
- o_PCSrc = i_Valid & ((i_Branch & i_Cero) | (i_NBranch & ~i_Cero)). Combinational, independent of stall.
- FSM IDLE:
  - Non-mem valid op: at the next edge load the MEM/WB registers with o_WB_Valid=1; o_Stall=0.
  - Aligned memop: o_Stall=1 combinationally, go to WAIT, counter cleared.
  - ~i_Valid: next edge gives o_WB_Valid=0.
- FSM WAIT:
  - o_MemReq=1. o_MemWe, o_MemAddr, o_MemBE, o_MemWData are driven from the held EX/MEM inputs, which upstream keeps stable because of o_Stall.
  - o_Stall = ~i_MemAck.
  - On i_MemAck: register the WB result with o_WB_Valid=1, go to IDLE. Minimum access latency is 2 cycles.
  - While waiting: o_WB_Valid=0 (bubble); counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without ack: abort. o_Stall=0 that cycle. Next edge: o_Timeout=1, o_WB_Valid=1, o_WB_RegWrite=0, state IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- Store lanes, with lane = i_ALU[1:0]:
  - byte: BE = 1<<lane, data = {4{i_Registro2[7:0]}}.
  - half: BE = lane[1] ? 1100 : 0011, data = {2{i_Registro2[15:0]}}.
  - word: BE = 1111.
- Load filter:
  - byte = i_MemRData[8*lane +: 8]; half = i_MemRData[16*lane[1] +: 16].
  - Extend to NBITS with zeros if i_ZeroExtend, otherwise sign-extend.
- Write-back select priority: i_JAL → i_PC8; i_LUI → {i_Extension[15:0], 16'h0}; i_MemToReg → filtered load; else i_ALU.
  - o_WB_RegWrite = i_RegWrite on a normal commit.
- Reset mid-WAIT returns to IDLE immediately; o_MemReq drops asynchronously.

Test Plan:
- ADD-type op, i_ALU=0x0000_1234, RegWrite=1, dest=5 → o_Stall=0 throughout; next edge o_WB_Data=0x1234, o_WB_RegistroDestino=5, o_WB_Valid=1.
- LB with i_ALU=0x103, RData=0x80FF_0000 ack after 3 cycles, ZeroExtend=0 → o_Stall high 3 cycles, o_MemAddr=0x100, o_WB_Data=0xFFFF_FF80.
- SH with i_ALU=0x202, Registro2=0xABCD → o_MemBE=1100, o_MemWData=0xABCD_ABCD, o_MemWe=1, o_WB_RegWrite=0.
- LW with i_ALU=0x101 → no o_MemReq, o_AddrError pulse, o_Stall=0.
- LW with no ack and TIMEOUT=16 → o_Stall high 16 cycles, then o_Timeout pulse, FSM back to IDLE.
- BNE with Cero=0 → o_PCSrc=1; JAL with PC8=0x40 → o_WB_Data=0x40; i_reset low during WAIT → o_MemReq=0 immediately, all WB outputs 0.
